// File: rtl/job_sequencer.sv
// Go/kill job sequencer: programmable-length active window with pause,
// abort, optional back-to-back restart and a completed-job counter.
module job_sequencer #(
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned JOBS_W = 8,
    parameter int unsigned REPEAT = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic              kill,
    input  logic              hold,
    input  logic [CNT_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [CNT_W-1:0]  count,
    output logic [2:0]        state,
    output logic [JOBS_W-1:0] jobs
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ACTIVE = 3'd1;
    localparam logic [2:0] S_PAUSE  = 3'd2;
    localparam logic [2:0] S_FINISH = 3'd3;
    localparam logic [2:0] S_ABORT  = 3'd4;

    localparam bit RESTART_EN = (REPEAT != 0);

    logic [2:0]       next_state;
    logic [CNT_W-1:0] len_reg;
    // High during the first ABORT cycle; delays the aborted pulse by one cycle
    logic             abort_entry;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; kill always wins
    always_comb begin
        next_state = S_IDLE;
        case (state)
            S_IDLE: begin
                if (!kill && go) begin
                    next_state = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (kill) begin
                    next_state = S_ABORT;
                end else if (hold) begin
                    next_state = S_PAUSE;
                end else if (count == len_reg) begin
                    next_state = S_FINISH;
                end else begin
                    next_state = S_ACTIVE;
                end
            end
            S_PAUSE: begin
                if (kill) begin
                    next_state = S_ABORT;
                end else if (hold) begin
                    next_state = S_PAUSE;
                end else begin
                    next_state = S_ACTIVE;
                end
            end
            S_FINISH: begin
                if (RESTART_EN && go && !kill) begin
                    next_state = S_ACTIVE;
                end
            end
            S_ABORT: begin
                if (kill) begin
                    next_state = S_ABORT;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Busy flag decoded straight from the state register
    always_comb begin
        busy = 1'b0;
        if (state == S_ACTIVE || state == S_PAUSE) begin
            busy = 1'b1;
        end
    end

    // Counter, latched length, job count and the done/aborted pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            count       <= '0;
            len_reg     <= '0;
            jobs        <= '0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            abort_entry <= 1'b0;
        end else begin
            done        <= (state == S_FINISH);
            abort_entry <= (state != S_ABORT) && (next_state == S_ABORT);
            aborted     <= abort_entry;
            case (state)
                S_IDLE: begin
                    if (next_state == S_ACTIVE) begin
                        len_reg <= len;
                        count   <= '0;
                    end
                end
                S_ACTIVE: begin
                    // Only the plain run case advances; kill/hold/terminal hold count
                    if (next_state == S_ACTIVE) begin
                        count <= count + CNT_W'(1);
                    end
                end
                S_PAUSE: begin
                    count <= count;
                end
                S_FINISH: begin
                    count <= '0;
                    jobs  <= jobs + JOBS_W'(1);
                    if (next_state == S_ACTIVE) begin
                        len_reg <= len;
                    end
                end
                S_ABORT: begin
                    count <= '0;
                end
                default: begin
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_job_sequencer.sv
// Directed bench for job_sequencer: cycle table on the default build plus
// hand sequences on a 4-bit counter build and a restart-enabled build.
module tb_job_sequencer;

    logic       clk;
    logic       reset;
    logic       go;
    logic       kill;
    logic       hold;
    logic [7:0] lenv;

    logic       busy0, done0, ab0;
    logic [7:0] cnt0;
    logic [2:0] st0;
    logic [7:0] jobs0;

    logic       busy1, done1, ab1;
    logic [3:0] cnt1;
    logic [2:0] st1;
    logic [7:0] jobs1;

    logic       busy2, done2, ab2;
    logic [7:0] cnt2;
    logic [2:0] st2;
    logic [7:0] jobs2;

    int checks;
    int errors;

    job_sequencer #(.CNT_W(8), .JOBS_W(8), .REPEAT(0)) u0 (
        .clk(clk), .reset(reset), .go(go), .kill(kill), .hold(hold), .len(lenv),
        .busy(busy0), .done(done0), .aborted(ab0), .count(cnt0), .state(st0), .jobs(jobs0)
    );

    job_sequencer #(.CNT_W(4), .JOBS_W(8), .REPEAT(0)) u1 (
        .clk(clk), .reset(reset), .go(go), .kill(kill), .hold(hold), .len(lenv[3:0]),
        .busy(busy1), .done(done1), .aborted(ab1), .count(cnt1), .state(st1), .jobs(jobs1)
    );

    job_sequencer #(.CNT_W(8), .JOBS_W(8), .REPEAT(1)) u2 (
        .clk(clk), .reset(reset), .go(go), .kill(kill), .hold(hold), .len(lenv),
        .busy(busy2), .done(done2), .aborted(ab2), .count(cnt2), .state(st2), .jobs(jobs2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       go;
        logic       kill;
        logic       hold;
        logic [7:0] len;
        logic [2:0] st;
        logic [7:0] cnt;
        logic       dn;
        logic       ab;
        logic [7:0] jb;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic g, input logic k, input logic h,
                       input logic [7:0] l, input logic [2:0] s, input logic [7:0] c,
                       input logic d, input logic a, input logic [7:0] j);
        vec_t v;
        v.rst = r; v.go = g; v.kill = k; v.hold = h; v.len = l;
        v.st = s; v.cnt = c; v.dn = d; v.ab = a; v.jb = j;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic g, input logic k, input logic h,
                         input logic [7:0] l);
        reset = r; go = g; kill = k; hold = h; lenv = l;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected u2 trace for REPEAT with go held: len 2, switched to 3 mid-job
    int rp_st  [14] = '{1, 1, 1, 3, 1, 1, 1, 3, 1, 1, 1, 1, 3, 1};
    int rp_cnt [14] = '{0, 1, 2, 2, 0, 1, 2, 2, 0, 1, 2, 3, 3, 0};
    int rp_dn  [14] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    initial begin
        int ndone;
        bit wrapped;
        checks = 0;
        errors = 0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);

        // Cycle table: inputs of a cycle, outputs expected in the next cycle
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // basic run len=3
        add(0, 1, 0, 0, 3, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 3, 1, 1, 0, 0, 0);
        add(0, 0, 0, 0, 3, 1, 2, 0, 0, 0);
        add(0, 0, 0, 0, 3, 1, 3, 0, 0, 0);
        add(0, 0, 0, 0, 3, 3, 3, 0, 0, 0);
        add(0, 0, 0, 0, 3, 0, 0, 1, 0, 1);
        add(0, 0, 0, 0, 3, 0, 0, 0, 0, 1);
        // hold for 3 cycles at count 2, len=5
        add(0, 1, 0, 0, 5, 1, 0, 0, 0, 1);
        add(0, 0, 0, 0, 5, 1, 1, 0, 0, 1);
        add(0, 0, 0, 0, 5, 1, 2, 0, 0, 1);
        add(0, 0, 0, 1, 5, 2, 2, 0, 0, 1);
        add(0, 0, 0, 1, 5, 2, 2, 0, 0, 1);
        add(0, 0, 0, 1, 5, 2, 2, 0, 0, 1);
        add(0, 0, 0, 0, 5, 1, 2, 0, 0, 1);
        add(0, 0, 0, 0, 5, 1, 3, 0, 0, 1);
        add(0, 0, 0, 0, 5, 1, 4, 0, 0, 1);
        add(0, 0, 0, 0, 5, 1, 5, 0, 0, 1);
        add(0, 0, 0, 0, 5, 3, 5, 0, 0, 1);
        add(0, 0, 0, 0, 5, 0, 0, 1, 0, 2);
        // abort at count 7 with kill held 4 cycles, len=20
        add(0, 1, 0, 0, 20, 1, 0, 0, 0, 2);
        for (int c = 1; c <= 7; c++) add(0, 0, 0, 0, 20, 1, 8'(c), 0, 0, 2);
        add(0, 0, 1, 0, 20, 4, 7, 0, 0, 2);
        add(0, 0, 1, 0, 20, 4, 0, 0, 1, 2);
        add(0, 0, 1, 0, 20, 4, 0, 0, 0, 2);
        add(0, 0, 1, 0, 20, 4, 0, 0, 0, 2);
        add(0, 0, 0, 0, 20, 0, 0, 0, 0, 2);
        // go with kill in IDLE stays idle
        add(0, 1, 1, 0, 20, 0, 0, 0, 0, 2);
        add(0, 0, 0, 0, 20, 0, 0, 0, 0, 2);
        // len=0: single ACTIVE cycle
        add(0, 1, 0, 0, 0, 1, 0, 0, 0, 2);
        add(0, 0, 0, 0, 0, 3, 0, 0, 0, 2);
        add(0, 0, 0, 0, 0, 0, 0, 1, 0, 3);
        // reset during PAUSE at count 4
        add(0, 1, 0, 0, 9, 1, 0, 0, 0, 3);
        for (int c = 1; c <= 4; c++) add(0, 0, 0, 0, 9, 1, 8'(c), 0, 0, 3);
        add(0, 0, 0, 1, 9, 2, 4, 0, 0, 3);
        add(1, 0, 0, 1, 9, 0, 0, 0, 0, 0);
        // reset in the FINISH cycle suppresses done
        add(0, 1, 0, 0, 1, 1, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 1, 1, 0, 0, 0);
        add(0, 0, 0, 0, 1, 3, 1, 0, 0, 0);
        add(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        // reset in the first ABORT cycle suppresses aborted
        add(0, 1, 0, 0, 4, 1, 0, 0, 0, 0);
        add(0, 0, 1, 0, 4, 4, 0, 0, 0, 0);
        add(1, 0, 0, 0, 4, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 4, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].go, vecs[i].kill, vecs[i].hold, vecs[i].len);
            tick();
            check($sformatf("row%0d state", i), int'(st0), int'(vecs[i].st));
            check($sformatf("row%0d count", i), int'(cnt0), int'(vecs[i].cnt));
            check($sformatf("row%0d done", i), int'(done0), int'(vecs[i].dn));
            check($sformatf("row%0d aborted", i), int'(ab0), int'(vecs[i].ab));
            check($sformatf("row%0d jobs", i), int'(jobs0), int'(vecs[i].jb));
            check($sformatf("row%0d busy", i), int'(busy0),
                  int'(vecs[i].st == 3'd1 || vecs[i].st == 3'd2));
        end

        // 4-bit counter reaches 15 without wrapping
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd15);
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'd15);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'd15);
        for (int t = 0; t <= 15; t++) begin
            check($sformatf("w4 state t%0d", t), int'(st1), 1);
            check($sformatf("w4 count t%0d", t), int'(cnt1), t);
            tick();
        end
        check("w4 finish state", int'(st1), 3);
        check("w4 finish count", int'(cnt1), 15);
        tick();
        check("w4 idle state", int'(st1), 0);
        check("w4 done", int'(done1), 1);
        check("w4 jobs", int'(jobs1), 1);

        // 256 len=0 jobs with go held: jobs wraps to 0
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        ndone = 0;
        wrapped = 1'b0;
        for (int t = 0; t < 1000 && !wrapped; t++) begin
            tick();
            if (done0) begin
                ndone++;
                if (ndone == 255) check("jobs at 255", int'(jobs0), 255);
                if (ndone == 256) begin
                    check("jobs wrap", int'(jobs0), 0);
                    wrapped = 1'b1;
                end
            end
        end
        check("wrap reached", int'(wrapped), 1);

        // REPEAT build with go held; len change applies at the next restart
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd2);
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'd2);
        for (int t = 0; t < 14; t++) begin
            tick();
            check($sformatf("rep state t%0d", t + 1), int'(st2), rp_st[t]);
            check($sformatf("rep count t%0d", t + 1), int'(cnt2), rp_cnt[t]);
            check($sformatf("rep done t%0d", t + 1), int'(done2), rp_dn[t]);
            if (t == 5) lenv = 8'd3;
        end
        check("rep jobs", int'(jobs2), 3);

        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
